mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles to wait for imem_ack/dmem_ack before fault; legal range 1..255.
REQ-002 Parameter ENABLE_CTRL_FLOW, default 1: 1 = BRANCH/JAL/JALR/LUI/AUIPC legal; 0 = only LOAD/STORE/OP-IMM/OP legal.
REQ-003 One clock; reset is asynchronous and active-high. Ports: clk input 1, clock. rst input 1, async active-high reset.
REQ-004 op  input  7: opcode of the fetched instruction, valid in the cycle imem_ack=1.
REQ-005 imem_req  output  1: instruction fetch request. imem_ack  input  1: fetch done.
REQ-006 dmem_req  output  1: data access request. dmem_ack  input  1: access done.
REQ-007 branch_taken  input  1: ALU compare result, sampled in EXEC.
REQ-008 ir_we  output  1: instruction register load strobe.
REQ-009 pc_we  output  1: PC write. pc_src  output  2: 00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1.
REQ-010 ALUSrc  output  1: 1 = ALU operand B from rs2, 0 = immediate. cal  output  1: force ALU ADD.
REQ-011 mem_load  output  1: data read. do_store  output  1: data write.
REQ-012 Reg_load  output  1: register-file write enable. Regwswitch  output  1: writeback data from memory.
REQ-013 wb_link  output  1: writeback data is pc+4.
REQ-014 retire  output  1: one-cycle pulse per completed instruction.
REQ-015 fault  output  1: sticky error flag. fault_code  output  2: 01 illegal opcode, 10 imem timeout, 11 dmem timeout.

Function
REQ-016 States: RST, FETCH, DECODE, EXEC, MEM, WB, TRAP; RST->FETCH unconditionally.
REQ-017 FETCH: imem_req=1; on imem_ack: ir_we=1, op latched, go DECODE.
REQ-018 DECODE: illegal opcode (per ENABLE_CTRL_FLOW) -> TRAP, code 01; else -> EXEC.
REQ-019 EXEC, LOAD/STORE: cal=1, ALUSrc=0, go MEM. OP-IMM: ALUSrc=0. OP: ALUSrc=1. LUI/AUIPC: cal=1, ALUSrc=0. All go WB.
REQ-020 EXEC, BRANCH: ALUSrc=1, pc_we=1, pc_src=01 if branch_taken else 00, retire=1, go FETCH.
REQ-021 EXEC, JAL/JALR: go WB.
REQ-022 MEM: dmem_req=1 held until ack; mem_load=1 for LOAD, do_store=1 for STORE.
REQ-023 MEM on dmem_ack: LOAD -> WB; STORE -> pc_we=1, pc_src=00, retire=1, go FETCH.
REQ-024 WB: Reg_load=1, pc_we=1, retire=1, go FETCH. Regwswitch=1 only for LOAD. wb_link=1 for JAL/JALR. pc_src=01 for JAL, 10 for JALR, else 00.
REQ-025 Wait counter: cleared on entering FETCH/MEM; increments each cycle without ack. When counter reaches MEM_TIMEOUT without ack -> TRAP, code 10 (FETCH) or 11 (MEM).
REQ-026 Ack in the same cycle the counter reaches MEM_TIMEOUT: ack wins, no fault.
REQ-027 TRAP: all strobes 0, fault=1, fault_code held; exit only by reset.
REQ-028 Strobes are decoded from state and latched op; any signal not listed for a state is 0.
REQ-029 Ack inputs outside their request state are ignored.

Reset
REQ-030 rst asserted: state=RST, counter=0, latched op=0, fault=0, fault_code=00.
REQ-031 All outputs are 0 while in RST; first imem_req occurs in the cycle after rst deasserts.
REQ-032 Reset mid-access abandons the request at once, with no retire or pc_we.

Structure
REQ-033 Shared package holds the opcode constants (LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111), the state enum, the pc_src encodings and the fault_code encodings.
REQ-034 One sub-module, mc_opdecode: combinational op -> {legal, class}; the FSM stays in mc_controller.

Verification
REQ-035 LOAD, acks after 2 cycles: FETCH->DECODE->EXEC->MEM->WB. WB asserts Reg_load=1 and Regwswitch=1. retire appears once, on cycle 7 after fetch start.
REQ-036 STORE, immediate acks: do_store=1 with dmem_req. No Reg_load. retire and pc_we occur in the MEM cycle.
REQ-037 BRANCH, branch_taken=1 -> pc_src=01. Repeat with branch_taken=0 -> pc_src=00. Run with ENABLE_CTRL_FLOW=0 -> TRAP, fault_code=01.
REQ-038 MEM_TIMEOUT=3, dmem_ack never asserted -> TRAP, fault_code=11, exactly 3 cycles after MEM entry. Repeat with ack on the 3rd cycle -> no fault.
REQ-039 Opcode 1111111 -> TRAP, fault=1 held for 20 cycles. rst pulse -> all outputs 0, then imem_req=1.
REQ-040 rst asserted mid-MEM -> dmem_req drops the same cycle, and no retire occurs.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg
//   Shared definitions for the multi-cycle controller: opcode constants,
//   controller state enum, decoded instruction class, pc_src and fault_code
//   encodings.
package mc_controller_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_LOAD,
    CLS_STORE,
    CLS_OPIMM,
    CLS_OP,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC
  } op_class_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PC_SRC_REL = 2'b01;  // pc + imm
  localparam logic [1:0] PC_SRC_REG = 2'b10;  // (rs1 + imm) & ~1

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_IMEM    = 2'b10;
  localparam logic [1:0] FAULT_DMEM    = 2'b11;

  // Classes that only exist when control-flow instructions are enabled.
  function automatic logic is_ctrl_flow(op_class_e cls);
    return cls inside {CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC};
  endfunction

endpackage

// File: rtl/mc_controller_opdecode.sv
// mc_opdecode
//   Combinational opcode classifier.
//   Ports:
//     op       in  [6:0]  opcode
//     legal    out        opcode is supported under ENABLE_CTRL_FLOW
//     op_class out        decoded instruction class (CLS_NONE if unknown)
module mc_opdecode
  import mc_controller_pkg::*;
#(
  parameter int unsigned ENABLE_CTRL_FLOW = 1
) (
  input  logic [6:0] op,
  output logic       legal,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CLS_NONE;
    case (op)
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_OPIMM:  op_class = CLS_OPIMM;
      OPC_OP:     op_class = CLS_OP;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_JAL:    op_class = CLS_JAL;
      OPC_JALR:   op_class = CLS_JALR;
      OPC_LUI:    op_class = CLS_LUI;
      OPC_AUIPC:  op_class = CLS_AUIPC;
      default:    op_class = CLS_NONE;
    endcase

    legal = (op_class != CLS_NONE);
    if ((ENABLE_CTRL_FLOW == 0) && is_ctrl_flow(op_class)) begin
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
//   Multi-cycle instruction sequencing FSM:
//   RST -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with TRAP as a
//   sticky sink for illegal opcodes and memory timeouts.
//   Ports:
//     clk, rst                   clock, async active-high reset
//     op                         opcode, valid while imem_ack=1
//     imem_req / imem_ack        instruction fetch handshake
//     dmem_req / dmem_ack        data access handshake
//     branch_taken               ALU compare result, used in EXEC
//     ir_we, pc_we, pc_src       IR load, PC write and PC source select
//     ALUSrc, cal                ALU operand-B select, force ADD
//     mem_load, do_store         data read / write qualifiers
//     Reg_load, Regwswitch,
//     wb_link                    register writeback controls
//     retire                     one pulse per completed instruction
//     fault, fault_code          sticky error flag and cause
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT      = 15,
  parameter int unsigned ENABLE_CTRL_FLOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  input  logic       dmem_ack,
  input  logic       branch_taken,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ALUSrc,
  output logic       cal,
  output logic       mem_load,
  output logic       do_store,
  output logic       Reg_load,
  output logic       Regwswitch,
  output logic       wb_link,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] op_q, op_d;
  logic       fault_q, fault_d;
  logic [1:0] fault_code_q, fault_code_d;

  logic       legal;
  op_class_e  op_class;
  logic [7:0] cnt_inc;

  // Decode always works on the latched opcode, never the live bus.
  mc_opdecode #(
    .ENABLE_CTRL_FLOW(ENABLE_CTRL_FLOW)
  ) u_opdecode (
    .op      (op_q),
    .legal   (legal),
    .op_class(op_class)
  );

  assign cnt_inc = cnt_q + 8'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RST;
      cnt_q        <= '0;
      op_q         <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          op_d    = op;
          state_d = ST_DECODE;
        end else begin
          // Ack in the terminal cycle takes the branch above, so it wins.
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            state_d      = ST_TRAP;
            fault_d      = 1'b1;
            fault_code_d = FAULT_IMEM;
          end
        end
      end
      ST_DECODE: begin
        if (!legal) begin
          state_d      = ST_TRAP;
          fault_d      = 1'b1;
          fault_code_d = FAULT_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: begin
            state_d = ST_MEM;
            cnt_d   = '0;
          end
          CLS_BRANCH: begin
            state_d = ST_FETCH;
            cnt_d   = '0;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (op_class == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            state_d      = ST_TRAP;
            fault_d      = 1'b1;
            fault_code_d = FAULT_DMEM;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_RST;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_SEQ;
    ALUSrc     = 1'b0;
    cal        = 1'b0;
    mem_load   = 1'b0;
    do_store   = 1'b0;
    Reg_load   = 1'b0;
    Regwswitch = 1'b0;
    wb_link    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      ST_EXEC: begin
        case (op_class)
          CLS_LOAD, CLS_STORE, CLS_LUI, CLS_AUIPC: cal = 1'b1;
          CLS_OP: ALUSrc = 1'b1;
          CLS_BRANCH: begin
            ALUSrc = 1'b1;
            pc_we  = 1'b1;
            pc_src = branch_taken ? PC_SRC_REL : PC_SRC_SEQ;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        mem_load = (op_class == CLS_LOAD);
        do_store = (op_class == CLS_STORE);
        // A store completes in MEM itself; there is no WB for it.
        if (dmem_ack && (op_class == CLS_STORE)) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        Reg_load   = 1'b1;
        pc_we      = 1'b1;
        retire     = 1'b1;
        Regwswitch = (op_class == CLS_LOAD);
        wb_link    = (op_class == CLS_JAL) || (op_class == CLS_JALR);
        if (op_class == CLS_JAL) begin
          pc_src = PC_SRC_REL;
        end else if (op_class == CLS_JALR) begin
          pc_src = PC_SRC_REG;
        end
      end
      default: ;
    endcase
  end

  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  localparam int T = 3;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  logic [6:0] legal_ops [9] = '{LOAD, STORE, OPIMM, OPR, BRANCH, JAL, JALR, LUI, AUIPC};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (MEM_TIMEOUT=3, control flow enabled)
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic       imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
  logic       imem_req, dmem_req, ir_we, pc_we, ALUSrc, cal, mem_load, do_store;
  logic       Reg_load, Regwswitch, wb_link, retire, fault;
  logic [1:0] pc_src, fault_code;

  mc_controller #(.MEM_TIMEOUT(T), .ENABLE_CTRL_FLOW(1)) dut (
    .clk(clk), .rst(rst), .op(op),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .ALUSrc(ALUSrc), .cal(cal), .mem_load(mem_load), .do_store(do_store),
    .Reg_load(Reg_load), .Regwswitch(Regwswitch), .wb_link(wb_link),
    .retire(retire), .fault(fault), .fault_code(fault_code)
  );

  // second DUT (control flow disabled, default timeout)
  logic       rst_2 = 1'b1;
  logic [6:0] op_2 = '0;
  logic       imem_ack_2 = 1'b0, dmem_ack_2 = 1'b0, branch_taken_2 = 1'b0;
  logic       imem_req_2, dmem_req_2, ir_we_2, pc_we_2, ALUSrc_2, cal_2, mem_load_2, do_store_2;
  logic       Reg_load_2, Regwswitch_2, wb_link_2, retire_2, fault_2;
  logic [1:0] pc_src_2, fault_code_2;

  mc_controller #(.ENABLE_CTRL_FLOW(0)) dut_nc (
    .clk(clk), .rst(rst_2), .op(op_2),
    .imem_req(imem_req_2), .imem_ack(imem_ack_2),
    .dmem_req(dmem_req_2), .dmem_ack(dmem_ack_2),
    .branch_taken(branch_taken_2), .ir_we(ir_we_2), .pc_we(pc_we_2), .pc_src(pc_src_2),
    .ALUSrc(ALUSrc_2), .cal(cal_2), .mem_load(mem_load_2), .do_store(do_store_2),
    .Reg_load(Reg_load_2), .Regwswitch(Regwswitch_2), .wb_link(wb_link_2),
    .retire(retire_2), .fault(fault_2), .fault_code(fault_code_2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // {imem_req, ir_we, dmem_req, mem_load, do_store, pc_we, pc_src, ALUSrc, cal,
  //  Reg_load, Regwswitch, wb_link, retire}
  function automatic logic [13:0] obs_vec();
    return {imem_req, ir_we, dmem_req, mem_load, do_store, pc_we, pc_src,
            ALUSrc, cal, Reg_load, Regwswitch, wb_link, retire};
  endfunction

  function automatic logic [13:0] ret_obs(logic dreq, logic dst, logic [1:0] psrc,
                                          logic asrc, logic rl, logic rws, logic link);
    return {2'b00, dreq, 1'b0, dst, 1'b1, psrc, asrc, 1'b0, rl, rws, link, 1'b1};
  endfunction

  typedef struct {
    int          cyc;
    bit          is_fault;
    logic [1:0]  code;
    logic [13:0] obs;
  } exp_t;

  exp_t sb[$];

  function automatic bit is_legal(logic [6:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: when and how an instruction starting its fetch in cycle s ends.
  // fd / md = cycle of the request in which the ack arrives (>T means never).
  function automatic exp_t model(int s, logic [6:0] o, int fd, int md, bit bt);
    exp_t e;
    int m;
    e.cyc = 0; e.is_fault = 1'b0; e.code = 2'b00; e.obs = '0;
    if (fd > T) begin
      e.cyc = s + T; e.is_fault = 1'b1; e.code = 2'b10;
      return e;
    end
    if (!is_legal(o)) begin
      e.cyc = s + fd + 1; e.is_fault = 1'b1; e.code = 2'b01;
      return e;
    end
    m = s + fd + 2;  // first cycle after EXEC
    if (o == BRANCH) begin
      e.cyc = s + fd + 1;
      e.obs = ret_obs(1'b0, 1'b0, bt ? 2'b01 : 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end else if (o == LOAD || o == STORE) begin
      if (md > T) begin
        e.cyc = m + T; e.is_fault = 1'b1; e.code = 2'b11;
      end else if (o == STORE) begin
        e.cyc = m + md - 1;
        e.obs = ret_obs(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        e.cyc = m + md;
        e.obs = ret_obs(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      end
    end else if (o == JAL) begin
      e.cyc = m; e.obs = ret_obs(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    end else if (o == JALR) begin
      e.cyc = m; e.obs = ret_obs(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    end else begin
      e.cyc = m; e.obs = ret_obs(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    return e;
  endfunction

  // ---------------- driver (memory responder) ----------------
  logic [6:0] cur_op = '0;
  int         cur_fd = 1, cur_md = 1;
  bit         cur_bt = 1'b0;
  int         fcnt = 0, mcnt = 0;
  int         next_start = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle();
    if (imem_req) begin
      fcnt++;
      imem_ack = (fcnt == cur_fd);
    end else begin
      imem_ack = ($urandom_range(3) == 0);
    end
    op = (imem_req && imem_ack) ? cur_op : 7'($urandom);
    if (dmem_req) begin
      mcnt++;
      dmem_ack = (mcnt == cur_md);
    end else begin
      dmem_ack = ($urandom_range(3) == 0);
    end
    branch_taken = cur_bt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); drive_cycle();
    step(); drive_cycle();
    rst = 1'b0;
    next_start = cyc + 1;
  endtask

  task automatic run_instr(logic [6:0] o, int fd, int md, bit bt, int abort);
    exp_t e;
    int last;
    e = model(next_start, o, fd, md, bt);
    cur_op = o; cur_fd = fd; cur_md = md; cur_bt = bt;
    fcnt = 0; mcnt = 0;
    if (abort >= 0) begin
      last = next_start + fd + 2 + abort;
    end else begin
      last = e.cyc;
      sb.push_back(e);
    end
    while (cyc < last) begin
      step();
      drive_cycle();
    end
    if (abort >= 0) begin
      do_reset();
    end else if (e.is_fault) begin
      repeat (20) begin step(); drive_cycle(); end
      do_reset();
    end else begin
      next_start = e.cyc + 1;
    end
  endtask

  function automatic int rand_dly();
    if ($urandom_range(9) == 0) return T + 1;
    return int'($urandom_range(T, 1));
  endfunction

  function automatic logic [6:0] rand_op();
    if ($urandom_range(4) == 0) return 7'($urandom);
    return legal_ops[$urandom_range(8)];
  endfunction

  task automatic main_seq();
    logic [6:0] o;
    int fd, md, ab;
    bit bt;
    step(); step();
    rst = 1'b0;
    next_start = cyc + 1;
    run_instr(LOAD,   2, 2, 1'b0, -1);
    run_instr(STORE,  1, 1, 1'b0, -1);
    run_instr(BRANCH, 1, 1, 1'b1, -1);
    run_instr(BRANCH, 3, 1, 1'b0, -1);
    run_instr(JAL,    1, 1, 1'b0, -1);
    run_instr(JALR,   2, 1, 1'b1, -1);
    run_instr(LUI,    1, 1, 1'b0, -1);
    run_instr(AUIPC,  1, 1, 1'b0, -1);
    run_instr(OPR,    1, 1, 1'b0, -1);
    run_instr(OPIMM,  1, 1, 1'b0, -1);
    run_instr(LOAD,   1, 3, 1'b0, -1);
    run_instr(STORE,  1, 3, 1'b0, -1);
    run_instr(LOAD,   1, T + 1, 1'b0, -1);
    run_instr(OPR,    T + 1, 1, 1'b0, -1);
    run_instr(7'h7f,  1, 1, 1'b0, -1);
    run_instr(LOAD,   1, 3, 1'b0, 1);
    run_instr(STORE,  2, 2, 1'b0, 0);
    run_instr(OPR,    1, 1, 1'b0, -1);
    for (int i = 0; i < 60; i++) begin
      o  = rand_op();
      fd = rand_dly();
      md = rand_dly();
      bt = 1'($urandom_range(1));
      ab = -1;
      if ((o == LOAD || o == STORE) && fd <= T && $urandom_range(7) == 0) begin
        md = int'($urandom_range(T, 1));
        ab = int'($urandom_range(md - 1, 0));
      end
      run_instr(o, fd, md, bt, ab);
    end
    repeat (4) begin step(); drive_cycle(); end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit         in_trap = 1'b0;
  logic [1:0] trap_code = 2'b00;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_trap = 1'b0;
        chk("reset_outputs", {15'd0, fault, fault_code, obs_vec()}, 32'd0);
      end else if (in_trap) begin
        chk("trap_hold", {15'd0, fault, fault_code, obs_vec()}, {15'd0, 1'b1, trap_code, 14'd0});
      end else if (retire || fault) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {30'd0, retire, fault}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_kind", {31'd0, fault}, {31'd0, e.is_fault});
          if (fault) begin
            chk("fault_code", {30'd0, fault_code}, {30'd0, e.code});
            chk("trap_strobes", {18'd0, obs_vec()}, 32'd0);
            in_trap   = 1'b1;
            trap_code = e.code;
          end else begin
            chk("retire_strobes", {18'd0, obs_vec()}, {18'd0, e.obs});
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        chk("missing_event", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // ---------------- directed run on the control-flow-disabled DUT ----------------
  task automatic nc_run();
    repeat (2) @(negedge clk);
    rst_2 = 1'b0;
    #1;
    chk("nc_rst_cycle_idle", {31'd0, imem_req_2}, 32'd0);
    @(negedge clk);                       // FETCH
    chk("nc_first_fetch", {31'd0, imem_req_2}, 32'd1);
    imem_ack_2 = 1'b1; op_2 = OPR;
    @(negedge clk);                       // DECODE
    imem_ack_2 = 1'b0; op_2 = BRANCH;
    @(negedge clk);                       // EXEC
    chk("nc_op_alusrc", {31'd0, ALUSrc_2}, 32'd1);
    @(negedge clk);                       // WB
    chk("nc_op_retire", {29'd0, retire_2, Reg_load_2, pc_we_2}, 32'd7);
    @(negedge clk);                       // FETCH
    chk("nc_second_fetch", {31'd0, imem_req_2}, 32'd1);
    imem_ack_2 = 1'b1; op_2 = BRANCH;
    @(negedge clk);                       // DECODE
    imem_ack_2 = 1'b0;
    chk("nc_no_fault_yet", {31'd0, fault_2}, 32'd0);
    @(negedge clk);                       // TRAP
    chk("nc_branch_trap", {29'd0, fault_2, fault_code_2}, 32'd5);
    imem_ack_2 = 1'b1; dmem_ack_2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("nc_trap_sticky", {27'd0, fault_2, fault_code_2, imem_req_2, dmem_req_2}, 32'd20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      main_seq();
      nc_run();
    join
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
